// File: rtl/gpu_axi_burst_master_if.sv
// AXI4 master-side bus bundle (AW/W/B/AR/R) carrying only the handshake, address,
// length, data and response fields; the static sideband is tied off by the parent.
// master modport: drives addresses, write data and ready for B/R; slave modport mirrors it.
interface gpu_axi_burst_master_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32
);
    logic [ADDR_WIDTH-1:0] awaddr;
    logic [7:0]            awlen;
    logic                  awvalid;
    logic                  awready;
    logic [DATA_WIDTH-1:0] wdata;
    logic                  wlast;
    logic                  wvalid;
    logic                  wready;
    logic [1:0]            bresp;
    logic                  bvalid;
    logic                  bready;
    logic [ADDR_WIDTH-1:0] araddr;
    logic [7:0]            arlen;
    logic                  arvalid;
    logic                  arready;
    logic [DATA_WIDTH-1:0] rdata;
    logic [1:0]            rresp;
    logic                  rvalid;
    logic                  rready;

    modport master (
        output awaddr, awlen, awvalid, wdata, wlast, wvalid, bready,
               araddr, arlen, arvalid, rready,
        input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );

    modport slave (
        input  awaddr, awlen, awvalid, wdata, wlast, wvalid, bready,
               araddr, arlen, arvalid, rready,
        output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );
endinterface

// File: rtl/gpu_axi_burst_master.sv
// Purpose: turns one GPU memory request (1..MAX_BURST beats) into AXI4 INCR bursts, split at 4KB.
// Latency: AXI valids rise 1 cycle after accept; o_done pulses 1 cycle after the final B/R handshake.
// Backpressure: one request at a time (o_req_ready only in IDLE); W and R are pass-through and stall on either side.
// Ports: clk/rst; i_req_* request in / o_req_ready; i_wr_* write beats in / o_wr_ready;
//        o_rd_* read beats out / i_rd_ready; o_done pulse, o_err sticky; m_axi master bus bundle.
module gpu_axi_burst_master #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int MAX_BURST  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_req_valid,
    output logic                  o_req_ready,
    input  logic                  i_req_we,
    input  logic [ADDR_WIDTH-1:0] i_req_addr,
    input  logic [7:0]            i_req_len,
    input  logic                  i_wr_valid,
    output logic                  o_wr_ready,
    input  logic [DATA_WIDTH-1:0] i_wr_data,
    output logic                  o_rd_valid,
    input  logic                  i_rd_ready,
    output logic [DATA_WIDTH-1:0] o_rd_data,
    output logic                  o_rd_last,
    output logic                  o_done,
    output logic                  o_err,
    gpu_axi_burst_master_if.master m_axi
);
    localparam int BYTES = DATA_WIDTH / 8;
    localparam int LG    = $clog2(BYTES);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_WR   = 3'd1;
    localparam logic [2:0] S_WB   = 3'd2;
    localparam logic [2:0] S_RD   = 3'd3;
    localparam logic [2:0] S_RR   = 3'd4;
    localparam logic [2:0] S_DONE = 3'd5;

    logic [2:0]            r_state;
    logic [ADDR_WIDTH-1:0] r_addr;     // start address of the current burst
    logic [7:0]            r_len;      // current burst beats minus one
    logic [8:0]            r_rem;      // beats left in the request, current burst included
    logic [7:0]            r_cnt;      // beats done in the current burst
    logic                  r_aw_done;
    logic                  r_w_done;
    logic                  r_err;

    logic [ADDR_WIDTH-1:0] w_addr_al;
    logic [8:0]            w_len1;
    logic [8:0]            w_beats;
    logic [8:0]            w_blen;
    logic [ADDR_WIDTH-1:0] w_next_addr;
    logic [8:0]            w_next_rem;
    logic                  w_accept;
    logic                  w_burst_last;
    logic                  w_w_act;
    logic                  w_rr;
    logic                  w_aw_hs;
    logic                  w_w_hs;
    logic                  w_r_hs;
    logic                  w_aw_fin;
    logic                  w_w_fin;

    // Burst length (minus one) that fits before the next 4KB boundary.
    // The start address is always beat aligned, so the room is an exact beat count.
    function automatic logic [7:0] f_burst_len(input logic [11:0] off, input logic [8:0] rem);
        logic [12:0] room;
        logic [12:0] n;
        room = (13'd4096 - {1'b0, off}) >> LG;
        n    = ({4'd0, rem} < room) ? {4'd0, rem} : room;
        return 8'(n - 13'd1);
    endfunction

    assign w_addr_al   = i_req_addr & ~ADDR_WIDTH'(BYTES - 1);
    assign w_len1      = {1'b0, i_req_len} + 9'd1;
    assign w_beats     = (w_len1 > 9'(MAX_BURST)) ? 9'(MAX_BURST) : w_len1;
    assign w_blen      = {1'b0, r_len} + 9'd1;
    // After a split the next burst starts exactly on the 4KB boundary.
    assign w_next_addr = r_addr + (ADDR_WIDTH'(w_blen) << LG);
    assign w_next_rem  = r_rem - w_blen;

    // Held low during reset so nothing can be accepted until IDLE is really live.
    assign o_req_ready  = (r_state == S_IDLE) && !rst;
    assign w_accept     = i_req_valid && o_req_ready;
    assign w_burst_last = (r_cnt == r_len);

    // Write path: AW and W run independently inside WR, each with its own done flag.
    assign w_w_act       = (r_state == S_WR) && !r_w_done;
    assign m_axi.awvalid = (r_state == S_WR) && !r_aw_done;
    assign m_axi.awaddr  = r_addr;
    assign m_axi.awlen   = r_len;
    assign m_axi.wvalid  = w_w_act && i_wr_valid;
    assign o_wr_ready    = w_w_act && m_axi.wready;
    assign m_axi.wdata   = w_w_act ? i_wr_data : '0;
    assign m_axi.wlast   = w_w_act && w_burst_last;
    assign m_axi.bready  = (r_state == S_WB);

    assign w_aw_hs  = m_axi.awvalid && m_axi.awready;
    assign w_w_hs   = m_axi.wvalid && m_axi.wready;
    assign w_aw_fin = r_aw_done || w_aw_hs;
    assign w_w_fin  = r_w_done || (w_w_hs && w_burst_last);

    // Read path: R is a straight pass-through; the local beat count, not rlast, ends a burst.
    assign w_rr          = (r_state == S_RR);
    assign m_axi.arvalid = (r_state == S_RD);
    assign m_axi.araddr  = r_addr;
    assign m_axi.arlen   = r_len;
    assign o_rd_valid    = w_rr && m_axi.rvalid;
    assign m_axi.rready  = w_rr && i_rd_ready;
    assign o_rd_data     = w_rr ? m_axi.rdata : '0;
    // Last of the request only, never at a 4KB split point.
    assign o_rd_last     = o_rd_valid && w_burst_last && (w_next_rem == 9'd0);
    assign w_r_hs        = m_axi.rvalid && m_axi.rready;

    assign o_done = (r_state == S_DONE);
    assign o_err  = r_err;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_addr    <= '0;
            r_len     <= '0;
            r_rem     <= '0;
            r_cnt     <= '0;
            r_aw_done <= 1'b0;
            r_w_done  <= 1'b0;
            r_err     <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_addr    <= w_addr_al;
                        r_rem     <= w_beats;
                        r_len     <= f_burst_len(w_addr_al[11:0], w_beats);
                        r_cnt     <= '0;
                        r_err     <= 1'b0;
                        r_aw_done <= 1'b0;
                        r_w_done  <= 1'b0;
                        r_state   <= i_req_we ? S_WR : S_RD;
                    end
                end
                S_WR: begin
                    if (w_aw_hs) begin
                        r_aw_done <= 1'b1;
                    end
                    if (w_w_hs) begin
                        if (w_burst_last) begin
                            r_w_done <= 1'b1;
                            r_cnt    <= '0;
                        end else begin
                            r_cnt <= r_cnt + 8'd1;
                        end
                    end
                    if (w_aw_fin && w_w_fin) begin
                        r_aw_done <= 1'b0;
                        r_w_done  <= 1'b0;
                        r_state   <= S_WB;
                    end
                end
                S_WB: begin
                    if (m_axi.bvalid) begin
                        if (m_axi.bresp != 2'b00) begin
                            r_err <= 1'b1;
                        end
                        if (w_next_rem == 9'd0) begin
                            r_state <= S_DONE;
                        end else begin
                            r_addr  <= w_next_addr;
                            r_rem   <= w_next_rem;
                            r_len   <= f_burst_len(w_next_addr[11:0], w_next_rem);
                            r_state <= S_WR;
                        end
                    end
                end
                S_RD: begin
                    if (m_axi.arready) begin
                        r_state <= S_RR;
                    end
                end
                S_RR: begin
                    if (w_r_hs) begin
                        if (m_axi.rresp != 2'b00) begin
                            r_err <= 1'b1;
                        end
                        if (w_burst_last) begin
                            r_cnt <= '0;
                            if (w_next_rem == 9'd0) begin
                                r_state <= S_DONE;
                            end else begin
                                r_addr  <= w_next_addr;
                                r_rem   <= w_next_rem;
                                r_len   <= f_burst_len(w_next_addr[11:0], w_next_rem);
                                r_state <= S_RD;
                            end
                        end else begin
                            r_cnt <= r_cnt + 8'd1;
                        end
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_gpu_axi_burst_master.sv
module tb_gpu_axi_burst_master;
    localparam int DW = 32;
    localparam int AW = 32;
    localparam int MB = 16;
    localparam int BYTES = DW / 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          i_req_valid, o_req_ready, i_req_we;
    logic [AW-1:0] i_req_addr;
    logic [7:0]    i_req_len;
    logic          i_wr_valid, o_wr_ready;
    logic [DW-1:0] i_wr_data;
    logic          o_rd_valid, i_rd_ready, o_rd_last, o_done, o_err;
    logic [DW-1:0] o_rd_data;

    always #5 clk = ~clk;

    gpu_axi_burst_master_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) axi();

    gpu_axi_burst_master #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .MAX_BURST(MB)) dut (
        .clk(clk), .rst(rst),
        .i_req_valid(i_req_valid), .o_req_ready(o_req_ready), .i_req_we(i_req_we),
        .i_req_addr(i_req_addr), .i_req_len(i_req_len),
        .i_wr_valid(i_wr_valid), .o_wr_ready(o_wr_ready), .i_wr_data(i_wr_data),
        .o_rd_valid(o_rd_valid), .i_rd_ready(i_rd_ready), .o_rd_data(o_rd_data),
        .o_rd_last(o_rd_last), .o_done(o_done), .o_err(o_err),
        .m_axi(axi)
    );

    typedef struct { logic [31:0] a; logic [7:0] l; } addr_t;
    typedef struct { logic [31:0] d; logic l; } beat_t;

    addr_t exp_aw[$], exp_ar[$], s_ar[$];
    beat_t exp_w[$], exp_r[$];
    logic  exp_done[$];

    int n_chk = 0, n_fail = 0, cyc = 0;
    int done_cnt = 0, b_hs_cnt = 0, last_cmp_cyc = 0;

    // stimulus knobs
    int rdy_pct = 100, wv_pct = 100, rr_pct = 100, rv_pct = 100, aw_delay = 0;
    bit rd_toggle = 0;
    int err_rbeat = -1, err_bburst = -1;

    // slave model state
    int s_aw_cnt = 0, s_wlast_cnt = 0, s_b_cnt = 0, s_r_cnt = 0, s_aw_wait = 0;
    int s_rleft = 0;
    logic [31:0] s_raddr = '0;
    int req_b_base = 0, req_r_base = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [31:0] f_rdata(input logic [31:0] a);
        return (a * 32'h9E3779B1) ^ 32'h5A5A0F0F;
    endfunction

    // Reference split rule: a request crossing 4KB becomes the part up to the boundary
    // plus the remainder starting at the next 4KB page.
    task automatic model_split(input logic [31:0] a, input int beats, output int nb,
                               output logic [31:0] ba0, output int bl0,
                               output logic [31:0] ba1, output int bl1);
        int off;
        off = int'(a & 32'hFFF);
        ba0 = a;
        if (off + beats * BYTES > 4096) begin
            nb  = 2;
            bl0 = (4096 - off) / BYTES;
            ba1 = (a | 32'hFFF) + 32'd1;
            bl1 = beats - bl0;
        end else begin
            nb  = 1;
            bl0 = beats;
            ba1 = '0;
            bl1 = 0;
        end
    endtask

    // ---------------- AXI slave model ----------------
    initial begin
        bit aw_hs, w_hs, wl, b_hs, ar_hs, r_hs;
        addr_t ar_c, e;
        axi.awready = 0; axi.wready = 0; axi.bvalid = 0; axi.bresp = 0;
        axi.arready = 0; axi.rvalid = 0; axi.rdata = 0; axi.rresp = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                s_aw_cnt = 0; s_wlast_cnt = 0; s_b_cnt = 0; s_r_cnt = 0; s_aw_wait = 0;
                s_rleft = 0; s_ar.delete();
                axi.awready = 0; axi.wready = 0; axi.bvalid = 0; axi.bresp = 0;
                axi.arready = 0; axi.rvalid = 0; axi.rresp = 0;
                continue;
            end
            aw_hs = axi.awvalid && axi.awready;
            w_hs  = axi.wvalid && axi.wready;
            wl    = axi.wlast;
            b_hs  = axi.bvalid && axi.bready;
            ar_hs = axi.arvalid && axi.arready;
            r_hs  = axi.rvalid && axi.rready;
            ar_c  = '{axi.araddr, axi.arlen};
            if (axi.awvalid && !aw_hs) s_aw_wait++;
            @(posedge clk);
            #1;
            if (rst) continue;
            if (aw_hs) begin s_aw_cnt++; s_aw_wait = 0; end
            if (w_hs && wl) s_wlast_cnt++;
            if (b_hs) begin s_b_cnt++; axi.bvalid = 0; end
            if (ar_hs) s_ar.push_back(ar_c);
            if (r_hs) begin s_raddr += BYTES; s_rleft--; s_r_cnt++; axi.rvalid = 0; end
            axi.awready = (s_aw_wait >= aw_delay) && ($urandom_range(0, 99) < rdy_pct);
            axi.wready  = ($urandom_range(0, 99) < rdy_pct);
            axi.arready = ($urandom_range(0, 99) < rdy_pct);
            if (!axi.bvalid && s_b_cnt < s_aw_cnt && s_b_cnt < s_wlast_cnt &&
                $urandom_range(0, 99) < rdy_pct) begin
                axi.bvalid = 1;
                axi.bresp  = ((s_b_cnt - req_b_base) == err_bburst) ? 2'b10 : 2'b00;
            end
            if (!axi.rvalid) begin
                if (s_rleft == 0 && s_ar.size() > 0) begin
                    e = s_ar.pop_front();
                    s_raddr = e.a;
                    s_rleft = int'(e.l) + 1;
                end
                if (s_rleft > 0 && $urandom_range(0, 99) < rv_pct) begin
                    axi.rvalid = 1;
                    axi.rdata  = f_rdata(s_raddr);
                    axi.rresp  = ((s_r_cnt - req_r_base) == err_rbeat) ? 2'b10 : 2'b00;
                end
            end
        end
    end

    // ---------------- monitor / scoreboard ----------------
    initial begin
        bit prev_aw_pend, prev_ar_pend, prev_done;
        addr_t ea;
        beat_t eb;
        logic ed;
        prev_aw_pend = 0; prev_ar_pend = 0; prev_done = 0;
        forever begin
            @(negedge clk);
            cyc++;
            if (rst) begin prev_aw_pend = 0; prev_ar_pend = 0; prev_done = 0; continue; end
            if (prev_aw_pend) check("awvalid_held", 64'(axi.awvalid), 64'd1);
            if (prev_ar_pend) check("arvalid_held", 64'(axi.arvalid), 64'd1);
            prev_aw_pend = axi.awvalid && !axi.awready;
            prev_ar_pend = axi.arvalid && !axi.arready;
            if (axi.awvalid && axi.awready) begin
                if (exp_aw.size() == 0) check("aw_unexpected", 64'd1, 64'd0);
                else begin
                    ea = exp_aw.pop_front();
                    check("awaddr", 64'(axi.awaddr), 64'(ea.a));
                    check("awlen", 64'(axi.awlen), 64'(ea.l));
                end
            end
            if (axi.arvalid && axi.arready) begin
                if (exp_ar.size() == 0) check("ar_unexpected", 64'd1, 64'd0);
                else begin
                    ea = exp_ar.pop_front();
                    check("araddr", 64'(axi.araddr), 64'(ea.a));
                    check("arlen", 64'(axi.arlen), 64'(ea.l));
                end
            end
            if (axi.wvalid && axi.wready) begin
                if (exp_w.size() == 0) check("w_unexpected", 64'd1, 64'd0);
                else begin
                    eb = exp_w.pop_front();
                    check("wdata", 64'(axi.wdata), 64'(eb.d));
                    check("wlast", 64'(axi.wlast), 64'(eb.l));
                end
            end
            if (o_rd_valid && i_rd_ready) begin
                last_cmp_cyc = cyc;
                if (exp_r.size() == 0) check("rd_unexpected", 64'd1, 64'd0);
                else begin
                    eb = exp_r.pop_front();
                    check("rd_data", 64'(o_rd_data), 64'(eb.d));
                    check("rd_last", 64'(o_rd_last), 64'(eb.l));
                end
            end
            if (axi.bvalid && axi.bready) begin
                last_cmp_cyc = cyc;
                b_hs_cnt++;
            end
            if (prev_done) check("done_one_cycle", 64'(o_done), 64'd0);
            prev_done = o_done;
            if (o_done) begin
                done_cnt++;
                if (exp_done.size() == 0) check("done_unexpected", 64'd1, 64'd0);
                else begin
                    ed = exp_done.pop_front();
                    check("err_at_done", 64'(o_err), 64'(ed));
                    check("done_latency", 64'(cyc - last_cmp_cyc), 64'd1);
                end
            end
        end
    end

    // ---------------- request driver ----------------
    task automatic do_req(input bit we, input logic [31:0] addr, input int len, input int abort);
        logic [31:0] aa, ba0, ba1, ba;
        int beats, nb, bl0, bl1, bl, k, widx, start_done, start_b;
        bit accepted, ok, first;
        logic [31:0] wd[$];
        logic exp_err;

        aa    = addr & ~32'(BYTES - 1);
        beats = (len + 1 > MB) ? MB : len + 1;
        model_split(aa, beats, nb, ba0, bl0, ba1, bl1);
        for (int i = 0; i < beats; i++) wd.push_back($urandom);
        k = 0;
        for (int b = 0; b < nb; b++) begin
            ba = (b == 0) ? ba0 : ba1;
            bl = (b == 0) ? bl0 : bl1;
            if (we) exp_aw.push_back('{ba, 8'(bl - 1)});
            else    exp_ar.push_back('{ba, 8'(bl - 1)});
            for (int j = 0; j < bl; j++) begin
                if (we) exp_w.push_back('{wd[k], (j == bl - 1)});
                else    exp_r.push_back('{f_rdata(ba + 32'(j * BYTES)), (k == beats - 1)});
                k++;
            end
        end
        exp_err = we ? (err_bburst >= 0 && err_bburst < nb) : (err_rbeat >= 0 && err_rbeat < beats);
        if (abort < 0) exp_done.push_back(exp_err);
        req_b_base = s_b_cnt;
        req_r_base = s_r_cnt;
        start_done = done_cnt;
        start_b    = b_hs_cnt;

        i_req_valid = 1; i_req_we = we; i_req_addr = addr; i_req_len = 8'(len);
        accepted = 0;
        for (int t = 0; t < 20; t++) begin
            @(negedge clk);
            if (o_req_ready) begin accepted = 1; break; end
            @(posedge clk); #1;
        end
        if (!accepted) check("req_accept_timeout", 64'd0, 64'd1);
        @(posedge clk); #1;
        i_req_valid = 0;

        widx = 0; ok = 0; first = 1;
        for (int t = 0; t < 3000; t++) begin
            if (we) begin
                i_wr_valid = (widx < beats) && ($urandom_range(0, 99) < wv_pct);
                i_wr_data  = (widx < beats) ? wd[widx] : '0;
            end else begin
                i_rd_ready = rd_toggle ? (t % 2 == 0) : ($urandom_range(0, 99) < rr_pct);
            end
            @(negedge clk);
            if (first) begin
                check("err_cleared_on_accept", 64'(o_err), 64'd0);
                check("req_ready_busy", 64'(o_req_ready), 64'd0);
                first = 0;
            end
            if (we && i_wr_valid && o_wr_ready) widx++;
            if (abort >= 0 && we && widx == abort) begin
                @(posedge clk);
                #3 rst = 1;
                #1;
                check("outs_zero_in_reset", 64'(|{o_req_ready, o_wr_ready, o_rd_valid, o_rd_data,
                      o_rd_last, o_done, o_err, axi.awaddr, axi.awlen, axi.awvalid, axi.wdata,
                      axi.wlast, axi.wvalid, axi.bready, axi.araddr, axi.arlen, axi.arvalid,
                      axi.rready}), 64'd0);
                i_wr_valid = 0;
                exp_aw.delete(); exp_w.delete(); exp_ar.delete(); exp_r.delete();
                repeat (2) @(posedge clk);
                #1 rst = 0;
                #1;
                check("req_ready_after_reset", 64'(o_req_ready), 64'd1);
                check("no_done_on_abort", 64'(done_cnt - start_done), 64'd0);
                return;
            end
            if (done_cnt != start_done) begin ok = 1; break; end
            @(posedge clk); #1;
        end
        if (!ok) check("done_timeout", 64'd0, 64'd1);
        if (we && ok) check("b_handshakes", 64'(b_hs_cnt - start_b), 64'(nb));
        i_wr_valid = 0;
        i_rd_ready = 0;
        @(posedge clk); #1;
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] ra;
        int rl;
        rst = 1; i_req_valid = 0; i_req_we = 0; i_req_addr = '0; i_req_len = '0;
        i_wr_valid = 0; i_wr_data = '0; i_rd_ready = 0;
        #2;
        check("reset_outs_zero", 64'(|{o_req_ready, o_wr_ready, o_rd_valid, o_done, o_err,
              axi.awvalid, axi.wvalid, axi.bready, axi.arvalid, axi.rready}), 64'd0);
        repeat (3) @(posedge clk);
        #1 rst = 0;
        #1 check("reset_release_ready", 64'(o_req_ready), 64'd1);
        @(posedge clk); #1;

        do_req(1, 32'h100, 3, -1);
        aw_delay = 3;
        do_req(1, 32'h40, 1, -1);
        aw_delay = 0;
        rd_toggle = 1;
        do_req(0, 32'h2000, 7, -1);
        rd_toggle = 0;
        do_req(1, 32'hFF8, 3, -1);
        do_req(0, 32'hFF8, 3, -1);
        err_rbeat = 1;
        do_req(0, 32'h500, 2, -1);
        err_rbeat = -1;
        do_req(0, 32'h600, 255, -1);
        err_bburst = 1;
        do_req(1, 32'h1FF0, 7, -1);
        err_bburst = -1;
        do_req(1, 32'h300, 3, 1);
        do_req(1, 32'h300, 3, -1);

        for (int n = 0; n < 60; n++) begin
            rdy_pct  = $urandom_range(30, 100);
            wv_pct   = $urandom_range(30, 100);
            rr_pct   = $urandom_range(30, 100);
            rv_pct   = $urandom_range(30, 100);
            aw_delay = $urandom_range(0, 3);
            ra = $urandom;
            if ($urandom_range(0, 1) == 1) ra = {ra[31:12], 12'hF00 + 12'($urandom_range(0, 255))};
            rl = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 255) : $urandom_range(0, 20);
            err_rbeat  = ($urandom_range(0, 4) == 0) ? $urandom_range(0, 15) : -1;
            err_bburst = ($urandom_range(0, 4) == 0) ? $urandom_range(0, 1) : -1;
            do_req(1'($urandom_range(0, 1)), ra, rl, -1);
        end

        check("aw_queue_empty", 64'(exp_aw.size()), 64'd0);
        check("w_queue_empty", 64'(exp_w.size()), 64'd0);
        check("ar_queue_empty", 64'(exp_ar.size()), 64'd0);
        check("r_queue_empty", 64'(exp_r.size()), 64'd0);
        check("done_queue_empty", 64'(exp_done.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/gpu_axi_burst_master.md
Name:
gpu_axi_burst_master

Overview:
- Parametrised successor to the single-beat GPU DRAM master path.
- Takes one GPU memory request at a time (read or write, 1..MAX_BURST beats) and issues it as AXI4 INCR bursts.
- Issues AW and W concurrently, splits bursts at 4KB boundaries, streams read data with backpressure and reports sticky error status.
- Sits between the gpu_top DRAM port and the external AXI4 memory interconnect.

Parameters:
DATA_WIDTH, 32, AXI data width in bits (power of two, ≥32); BYTES = DATA_WIDTH/8.
ADDR_WIDTH, 32, AXI and request address width.
MAX_BURST, 16, maximum beats per request (power of two, 1..256).

Ports:
clk  in  1  single clock, all logic rising-edge.
rst  in  1  asynchronous, active-high reset.
i_req_valid  in  1  request valid.
o_req_ready  out  1  request accepted when valid&&ready; high only in IDLE.
i_req_we  in  1  1=write, 0=read.
i_req_addr  in  ADDR_WIDTH  byte start address.
i_req_len  in  8  beats minus one.
i_wr_valid  in  1  write data beat valid.
o_wr_ready  out  1  write data beat consumed.
i_wr_data  in  DATA_WIDTH  write data beat.
o_rd_valid  out  1  read data beat valid.
i_rd_ready  in  1  read consumer ready.
o_rd_data  out  DATA_WIDTH  read data beat.
o_rd_last  out  1  final beat of the whole request.
o_done  out  1  one-cycle pulse when the request completes.
o_err  out  1  sticky: some response of current/last request was not OKAY.
m_axi_awaddr  out  ADDR_WIDTH  burst write address.
m_axi_awlen  out  8  burst beats minus one.
m_axi_awvalid  out  1  AW valid.
m_axi_awready  in  1  AW ready.
m_axi_wdata  out  DATA_WIDTH  write data (= i_wr_data).
m_axi_wlast  out  1  last beat of current burst.
m_axi_wvalid  out  1  W valid.
m_axi_wready  in  1  W ready.
m_axi_bresp  in  2  write response.
m_axi_bvalid  in  1  B valid.
m_axi_bready  out  1  B ready.
m_axi_araddr  out  ADDR_WIDTH  burst read address.
m_axi_arlen  out  8  burst beats minus one.
m_axi_arvalid  out  1  AR valid.
m_axi_arready  in  1  AR ready.
m_axi_rdata  in  DATA_WIDTH  read data.
m_axi_rresp  in  2  read response.
m_axi_rvalid  in  1  R valid.
m_axi_rready  out  1  R ready.

Behaviour:
- Reset: rst asserted → state IDLE immediately, all outputs 0 (o_req_ready 0 while rst high, 1 in the first IDLE cycle after release). Reset mid-burst abandons the transaction with no o_done. AXI sideband (ID 0, SIZE log2(BYTES), INCR, WSTRB all ones, CACHE 0011) is tied off in the parent wrapper, not in this block.
- Accept (IDLE, i_req_valid&&o_req_ready):
  - Latch addr with low log2(BYTES) bits forced to 0.
  - Latch beats = min(i_req_len+1, MAX_BURST) and we.
  - Clear o_err.
  - Next state WR or RD; AXI valids rise the next cycle (1-cycle latency).
- 4KB split: if off=addr[11:0] and off+beats*BYTES > 4096:
  - Burst 1: b1=(4096-off)/BYTES beats at addr.
  - Burst 2: beats-b1 beats at (addr|0xFFF)+1.
  - awlen/arlen = burst beats-1; addr/len outputs stable for the whole burst.
- WR:
  - awvalid held from entry until awready.
  - In parallel: m_axi_wvalid=i_wr_valid, o_wr_ready=m_axi_wready, both gated by beats remaining in the burst.
  - Beat counts on wvalid&&wready; wlast on the final beat of the current burst.
  - W may finish before AW or vice versa; per-channel done flags.
  - Both done → WB.
- WB: bready=1; on bvalid → WR (split pending) or DONE.
- RD:
  - arvalid until arready → RR.
  - RR is combinational pass-through: o_rd_valid=m_axi_rvalid, m_axi_rready=i_rd_ready, o_rd_data=m_axi_rdata.
  - Beat counts on rvalid&&rready; o_rd_last only on the final beat of the request, never at the split point.
  - Burst-final beat → RD (split pending) or DONE.
  - m_axi_rlast is not used; the beat count governs.
- DONE: o_done=1 for one cycle → IDLE. Back-to-back requests have 1 idle cycle minimum.
- Errors: any bresp/rresp≠00 sets o_err; it stays set through DONE until the next accept. All beats still complete.
- Stalls: i_wr_valid low → wvalid low, no beat counted. AXI valids never drop without handshake. No request is accepted outside IDLE.

Test Plan:
- Write addr 0x100, len 3, awready and wready high → awaddr 0x100, awlen 3, 4 W beats, wlast on beat 4, o_done 1 cycle after bvalid, o_err 0.
- Write len 1 with awready delayed 3 cycles and both W beats accepted first → awvalid held, no extra W beats, single B, o_done.
- Read addr 0x2000, len 7, i_rd_ready toggling 1/0 → 8 beats delivered in order with no loss or duplication, o_rd_last only on beat 8.
- Write addr 0x0FF8, len 3 (32-bit data) → burst 0xFF8/awlen 1 then 0x1000/awlen 1, two B handshakes, one o_done. Repeat as a read: o_rd_last only on beat 4.
- Read len 2 with rresp=10 on beat 2 → all 3 beats delivered, o_err 1 after DONE and cleared at the next accept. len 255 with MAX_BURST 16 → 16 beats.
- rst pulsed during beat 2 of a 4-beat write → all outputs 0 asynchronously, no o_done, next request works normally.
